ipm_shift_seq: RTL and testbench
================================

IPM_SHIFT_SEQ -- requirements
Module: ipm_shift_seq

Interface
REQ-001 SHALL expose parameter V, default 3: number of IPM share bytes, legal range 2..16.
REQ-002 SHALL have `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have `rst_n`, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have `in_valid`, input, 1 bit: request carries a share and a public-L update.
REQ-005 SHALL have `in_ready`, output, 1 bit: the block accepts a request when both `in_valid` and `in_ready` are high.
REQ-006 SHALL have `in_share`, input, V*8 bits: IPM share (not IPM-RED); byte j occupies bits [8j+7:8j].
REQ-007 SHALL have `l_old` and `l_new`, input, V*8 bits each: public L vectors in the same byte layout; byte 0 is ignored.
REQ-008 SHALL have `out_valid`, input-side counterpart `out_ready` (input, 1 bit), and `out_share` (output, V*8 bits) forming the result handshake.
REQ-009 SHALL have `busy`, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SHALL compute `out_share`: bytes 1..V-1 equal the captured `in_share` bytes; byte 0 = in_share[0] XOR sum over j=1..V-1 of gmul(l_old[j] XOR l_new[j], in_share[j]).
REQ-011 gmul SHALL be GF(2^8) multiplication modulo x^8+x^4+x^3+x+1 (0x11B); the sum is XOR.
REQ-012 SHALL use exactly one combinational GF(2^8) multiplier, time-shared: one product per RUN cycle.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 IDLE: `in_ready`=1; on acceptance, the block registers `in_share` and delta = l_old XOR l_new, loads accumulator = in_share[0], loads index = 1, and enters RUN.
REQ-015 RUN: each cycle, accumulator ^= gmul(delta[index], share[index]) and index increments; after processing index V-1, the FSM enters DONE.
REQ-016 DONE: `out_valid`=1 and `out_share` holds stable until `out_valid` and `out_ready` are both high; the FSM then returns to IDLE.
REQ-017 Latency SHALL be such that `out_valid` first rises exactly V cycles after the accepting cycle (macro absent).
REQ-018 `in_ready` SHALL be 0 in RUN and DONE; inputs are not sampled outside acceptance.
REQ-019 Throughput: after an output handshake, the earliest next acceptance is the following cycle (in IDLE).
REQ-020 `out_ready` held low SHALL stall the block in DONE indefinitely with no change to outputs.
REQ-021 `out_share` SHALL be driven only from registers; when not in DONE its value is don't-care but must not be X after reset.

Reset
REQ-022 While `rst_n`=0 at an edge: state=IDLE, accumulator/index/share/delta registers=0, `out_valid`=0, `busy`=0, `in_ready`=0.
REQ-023 `in_ready` SHALL rise the cycle after `rst_n` deasserts.
REQ-024 Reset asserted during RUN or DONE SHALL abandon the operation with no output handshake and return to IDLE.

Configuration
REQ-025 Macro `IPM_SHIFT_SKIPZERO_EN` defined: at acceptance, a mask of nonzero delta bytes 1..V-1 is captured; each RUN cycle processes the lowest remaining set bit and clears it; RUN ends when the mask is empty; if the mask is empty at acceptance, the FSM goes directly to DONE.
REQ-026 With the macro defined, latency SHALL be 1+N cycles, where N is the number of nonzero delta bytes; results are identical to those without the macro.
REQ-027 Macro undefined: no mask logic, fixed latency of V cycles, all indices processed regardless of delta.

Verification
REQ-028 V=3; in bytes {b0=0x00,b1=0x03,b2=0x01}, l_old=0, l_new {b1=0x02,b2=0x05} -> out b0=0x03, b1=0x03, b2=0x01, with `out_valid` 3 cycles after acceptance.
REQ-029 V=2; in {b0=0xFF,b1=0x83}, delta b1=0x57 -> out b0=0x3E (0x57*0x83=0xC1).
REQ-030 `out_ready` held low for 10 cycles in DONE -> `out_valid` and `out_share` stay stable and `in_ready` stays 0; release -> IDLE the next cycle.
REQ-031 `rst_n` low mid-RUN -> next cycle state IDLE, `out_valid`=0, `busy`=0; no result emitted.
REQ-032 With `IPM_SHIFT_SKIPZERO_EN`, V=3, l_old=l_new -> `out_valid` 1 cycle after acceptance and out=in; with only b2 delta nonzero -> 2 cycles.
REQ-033 Back-to-back: 4 random requests with `out_ready`=1 -> each result matches the reference model and each acceptance is exactly 1 cycle after the previous output handshake.

Source files
------------

// File: rtl/ipm_shift_seq.sv
// ipm_shift_seq: IPM share refresh after a change of the public L vector.
// The share is captured and delta = l_old ^ l_new is formed at acceptance.
// Byte 0 is then corrected by XOR-accumulating gmul(delta[j], share[j])
// for j = 1..V-1. A single GF(2^8) multiplier handles one index per RUN cycle.
// Optional feature macro: IPM_SHIFT_SKIPZERO_EN skips indices whose delta byte is zero.
module ipm_shift_seq #(
    parameter int V = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [V*8-1:0] in_share,
    input  logic [V*8-1:0] l_old,
    input  logic [V*8-1:0] l_new,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [V*8-1:0] out_share,
    output logic           busy
);

    localparam int IW = (V > 2) ? $clog2(V) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            p  = p ^ (aa & {8{b[k]}});
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [V*8-1:0] r_share;
    logic [V*8-1:0] r_delta;
    logic [7:0]     r_acc;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic [V*8-1:0] w_delta_in;
    logic [IW-1:0]  w_idx;
    logic [7:0]     w_op_a;
    logic [7:0]     w_op_b;
    logic [7:0]     w_prod;
    logic           w_accept;
    logic           w_run_last;

    assign w_delta_in = l_old ^ l_new;
    assign w_accept   = (r_state == ST_IDLE) && r_in_ready && in_valid;

`ifdef IPM_SHIFT_SKIPZERO_EN
    logic [V-1:0] r_mask;
    logic [V-1:0] w_mask_init;
    logic [V-1:0] w_onehot;

    // Mask of nonzero delta bytes at acceptance; byte 0 never takes part.
    always_comb begin
        w_mask_init = '0;
        for (int j = 1; j < V; j++) begin
            w_mask_init[j] = |w_delta_in[8*j +: 8];
        end
    end

    // Lowest pending index in the mask and its one-hot clear vector.
    always_comb begin
        w_idx    = '0;
        w_onehot = '0;
        for (int j = V - 1; j >= 1; j--) begin
            w_idx = r_mask[j] ? IW'(j) : w_idx;
        end
        for (int j = 1; j < V; j++) begin
            w_onehot[j] = (w_idx == IW'(j)) && r_mask[j];
        end
    end

    assign w_run_last = ((r_mask & ~w_onehot) == '0);
`else
    logic [IW-1:0] r_idx;

    assign w_idx      = r_idx;
    assign w_run_last = (r_idx == IW'(V - 1));
`endif

    // Operand select for the shared multiplier (AND-OR byte mux).
    always_comb begin
        w_op_a = 8'h00;
        w_op_b = 8'h00;
        for (int j = 0; j < V; j++) begin
            w_op_a = w_op_a | (r_delta[8*j +: 8] & {8{w_idx == IW'(j)}});
            w_op_b = w_op_b | (r_share[8*j +: 8] & {8{w_idx == IW'(j)}});
        end
    end

    assign w_prod = gf_mul(w_op_a, w_op_b);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef IPM_SHIFT_SKIPZERO_EN
                    w_state_nxt = (w_mask_init == '0) ? ST_DONE : ST_RUN;
`else
                    w_state_nxt = ST_RUN;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_run_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered handshake/status outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Datapath: capture at acceptance, one multiply-accumulate per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_share <= '0;
            r_delta <= '0;
            r_acc   <= 8'h00;
`ifdef IPM_SHIFT_SKIPZERO_EN
            r_mask  <= '0;
`else
            r_idx   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_share <= in_share;
                        r_delta <= w_delta_in;
                        r_acc   <= in_share[7:0];
`ifdef IPM_SHIFT_SKIPZERO_EN
                        r_mask  <= w_mask_init;
`else
                        r_idx   <= IW'(1);
`endif
                    end
                end
                ST_RUN: begin
                    r_acc  <= r_acc ^ w_prod;
`ifdef IPM_SHIFT_SKIPZERO_EN
                    r_mask <= r_mask & ~w_onehot;
`else
                    r_idx  <= r_idx + IW'(1);
`endif
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_share = {r_share[V*8-1:8], r_acc};

endmodule

// File: tb/tb_ipm_shift_seq.sv
// Scoreboard bench for ipm_shift_seq (V=3): directed vectors with
// hand-computed results, latency and handshake-timing checks.
module tb_ipm_shift_seq;

    localparam int V = 3;
    localparam int W = V * 8;
`ifdef IPM_SHIFT_SKIPZERO_EN
    localparam bit SKIPZ = 1'b1;
`else
    localparam bit SKIPZ = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_share  = '0;
    logic [W-1:0] l_old     = '0;
    logic [W-1:0] l_new     = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_share;
    logic         busy;

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int last_hs = -100;

    typedef struct {
        logic [W-1:0] exp;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_head;
    logic prev_ov = 1'b0;

    ipm_shift_seq #(.V(V)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_share  (in_share),
        .l_old     (l_old),
        .l_new     (l_new),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_share (out_share),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Expected latency in cycles from the accepting cycle to out_valid.
    function automatic int exp_lat(input logic [W-1:0] d);
        int n;
        n = 0;
        for (int j = 1; j < V; j++) begin
            if (d[8*j +: 8] != 8'h00) n++;
        end
        return SKIPZ ? (1 + n) : V;
    endfunction

    // Present a request; when it is accepted, push the expected result.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] lo, input logic [W-1:0] ln,
                        input logic [W-1:0] exp, input bit expect_out, input bit b2b);
        int n;
        @(negedge clk);
        in_share = s;
        l_old    = lo;
        l_new    = ln;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end else begin
            if (b2b) chk("b2b_accept_edge", cyc + 1, last_hs + 1);
            if (expect_out) sb_q.push_back('{exp: exp, lat: exp_lat(lo ^ ln), acc: cyc + 1});
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || out_valid) fail_now("drain_timeout");
    endtask

    // Monitor: latency on out_valid rise, result check on each output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && !prev_ov && sb_q.size() > 0) begin
            chk("latency", cyc - sb_q[0].acc + 1, sb_q[0].lat);
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", out_share);
            end else begin
                sb_head = sb_q.pop_front();
                chk("out_share", out_share, sb_head.exp);
            end
            last_hs = cyc + 1;
        end
        prev_ov = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_share", out_share, 24'h000000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1'b1);

        // Basic vector: delta {b1=02,b2=05}
        send(24'h010300, 24'h000000, 24'h050200, 24'h010303, 1'b1, 1'b0);
        drain();
        // delta b1=57, share b1=83 -> product C1; FF^C1=3E
        send(24'h5A83FF, 24'h331000, 24'h334700, 24'h5A833E, 1'b1, 1'b0);
        drain();
        // l_old == l_new: output equals input
        send(24'hC0FFEE, 24'h123456, 24'h123456, 24'hC0FFEE, 1'b1, 1'b0);
        drain();
        // Only b2 delta nonzero (03*02=06), byte 0 of L ignored
        send(24'h022010, 24'h0000AA, 24'h030055, 24'h022016, 1'b1, 1'b0);
        drain();

        // Stall in DONE: 80*02=1B, 80*04=36, 01^1B^36=2C
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(24'h040201, 24'h8080AA, 24'h000000, 24'h04022C, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("stall_wait_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_out_share", out_share, 24'h04022C);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);
        chk("release_busy", busy, 1'b0);
        drain();

        // Reset mid-RUN abandons the operation
        send(24'h111111, 24'h000000, 24'h222200, 24'h000000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready_rise", in_ready, 1'b1);
        repeat (6) @(negedge clk);
        chk("abort_no_result", out_valid, 1'b0);

        // Back-to-back requests with out_ready held high
        send(24'h010100, 24'h000000, 24'hCA5300, 24'h010199, 1'b1, 1'b0);
        send(24'h030255, 24'h0F0F00, 24'h0D0D00, 24'h030257, 1'b1, 1'b1);
        send(24'h0053AA, 24'h000000, 24'hFFCA00, 24'h0053AB, 1'b1, 1'b1);
        send(24'h135700, 24'h000000, 24'h018300, 24'h1357D2, 1'b1, 1'b1);
        drain();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
